// File: rtl/lingret_alu_loader.sv
// Lingret ALU loader: byte-serial front end that gathers instruction, operand A
// and operand B from a shared strobed byte bus, presents them to the
// combinational ALU, and registers the ALU result on the output pins.
module lingret_alu_loader #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_data,
   input  logic       i_strobe,
   output logic [7:0] o_instruction,
   output logic [7:0] o_data_0,
   output logic [7:0] o_data_1,
   output logic       o_alu_valid,
   input  logic [7:0] i_alu_result,
   output logic [7:0] o_result,
   output logic       o_result_valid,
   output logic       o_error,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      S_INSTR,
      S_OPA,
      S_OPB,
      S_EXEC,
      S_DONE
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [SYNC_STAGES-1:0] strobe_sync;
   logic                   strobe_prev;
   logic                   accept;
   logic                   op_illegal;
   logic                   chain;
   logic                   has_prev;

   // A byte is taken only on the first cycle the synchronized strobe is seen high,
   // so a long strobe still loads exactly one byte.
   assign accept     = strobe_sync[SYNC_STAGES-1] & ~strobe_prev;
   // Opcodes 110 and 111 are the only unsupported ones.
   assign op_illegal = (i_data[2:1] == 2'b11);
   assign chain      = i_data[3];

   // Strobe synchronizer chain plus the delayed copy used for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         strobe_sync <= '0;
         strobe_prev <= 1'b0;
      end else begin
         strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], i_strobe};
         strobe_prev <= strobe_sync[SYNC_STAGES-1];
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_INSTR;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and the state-derived ALU-valid and busy outputs.
   always_comb begin
      state_nxt   = state;
      o_alu_valid = 1'b0;
      o_busy      = 1'b0;
      case (state)
         S_INSTR, S_DONE: begin
            if (accept) begin
               if (op_illegal) begin
                  state_nxt = S_DONE;
               end else if (chain) begin
                  state_nxt = S_OPB;
               end else begin
                  state_nxt = S_OPA;
               end
            end
         end
         S_OPA: begin
            o_busy = 1'b1;
            if (accept) begin
               state_nxt = S_OPB;
            end
         end
         S_OPB: begin
            o_busy = 1'b1;
            if (accept) begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            o_busy      = 1'b1;
            o_alu_valid = 1'b1;
            state_nxt   = S_DONE;
         end
         default: begin
            state_nxt = S_INSTR;
         end
      endcase
   end

   // Byte capture, result capture and status flags; a reset discards partial bytes.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_instruction  <= 8'h00;
         o_data_0       <= 8'h00;
         o_data_1       <= 8'h00;
         o_result       <= 8'h00;
         o_result_valid <= 1'b0;
         o_error        <= 1'b0;
         has_prev       <= 1'b0;
      end else begin
         case (state)
            S_INSTR, S_DONE: begin
               if (accept) begin
                  o_instruction <= i_data;
                  if (op_illegal) begin
                     // Rejected instruction completes at once with a zero result and
                     // breaks any chain, so a following chained op starts from 0.
                     o_result       <= 8'h00;
                     o_error        <= 1'b1;
                     o_result_valid <= 1'b1;
                     has_prev       <= 1'b0;
                  end else begin
                     o_result_valid <= 1'b0;
                     o_error        <= 1'b0;
                     if (chain) begin
                        o_data_0 <= has_prev ? o_result : 8'h00;
                     end
                  end
               end
            end
            S_OPA: begin
               if (accept) begin
                  o_data_0 <= i_data;
               end
            end
            S_OPB: begin
               if (accept) begin
                  o_data_1 <= i_data;
               end
            end
            S_EXEC: begin
               o_result       <= i_alu_result;
               o_result_valid <= 1'b1;
               has_prev       <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lingret_alu_loader.sv
// Testbench for lingret_alu_loader: two instances (2- and 3-stage strobe
// synchronizers) share one stimulus stream; a scoreboard checks every EXEC.
module tb_lingret_alu_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] i_data;
   logic       i_strobe;

   logic [7:0] instr2, d0_2, d1_2, res2, alu2;
   logic       av2, rv2, err2, busy2;
   logic [7:0] instr3, d0_3, d1_3, res3, alu3;
   logic       av3, rv3, err3, busy3;

   // Bench ALU model standing in for the downstream combinational ALU.
   function automatic logic [7:0] alu_model(input logic [7:0] ins, input logic [7:0] a,
                                            input logic [7:0] b);
      case (ins[2:0])
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return a - b;
         3'd4:    return a + b;
         3'd5:    return ~(a & b);
         default: return 8'h00;
      endcase
   endfunction

   assign alu2 = alu_model(instr2, d0_2, d1_2);
   assign alu3 = alu_model(instr3, d0_3, d1_3);

   lingret_alu_loader #(.SYNC_STAGES(2)) dut2 (
      .clk(clk), .rst(rst), .i_data(i_data), .i_strobe(i_strobe),
      .o_instruction(instr2), .o_data_0(d0_2), .o_data_1(d1_2), .o_alu_valid(av2),
      .i_alu_result(alu2), .o_result(res2), .o_result_valid(rv2), .o_error(err2),
      .o_busy(busy2)
   );

   lingret_alu_loader #(.SYNC_STAGES(3)) dut3 (
      .clk(clk), .rst(rst), .i_data(i_data), .i_strobe(i_strobe),
      .o_instruction(instr3), .o_data_0(d0_3), .o_data_1(d1_3), .o_alu_valid(av3),
      .i_alu_result(alu3), .o_result(res3), .o_result_valid(rv3), .o_error(err3),
      .o_busy(busy3)
   );

   int errors = 0;
   int checks = 0;
   int exec2  = 0;
   int exec3  = 0;

   typedef struct packed {
      logic [7:0] instr;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
   } txn_t;

   txn_t q2[$];
   txn_t q3[$];

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_txn(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] res);
      txn_t t;
      t = '{instr: ins, a: a, b: b, res: res};
      q2.push_back(t);
      q3.push_back(t);
   endtask

   // Scoreboard: on each EXEC cycle pop the expected transaction, check operands,
   // then check the registered result on the following cycle.
   initial begin
      txn_t cur2, cur3;
      logic pend2, pend3;
      pend2 = 1'b0;
      pend3 = 1'b0;
      cur2  = '0;
      cur3  = '0;
      forever begin
         @(negedge clk);
         if (pend2) begin
            chk("sb2_result", 40'({res2, rv2, err2}), 40'({cur2.res, 1'b1, 1'b0}));
            pend2 = 1'b0;
         end
         if (pend3) begin
            chk("sb3_result", 40'({res3, rv3, err3}), 40'({cur3.res, 1'b1, 1'b0}));
            pend3 = 1'b0;
         end
         if (av2) begin
            exec2++;
            checks++;
            assert (q2.size() > 0) else begin
               errors++;
               $error("FAIL sb2_unexpected_exec observed=exec expected=no_exec");
            end
            if (q2.size() > 0) begin
               cur2 = q2.pop_front();
               chk("sb2_operands", 40'({instr2, d0_2, d1_2}), 40'({cur2.instr, cur2.a, cur2.b}));
               pend2 = 1'b1;
            end
         end
         if (av3) begin
            exec3++;
            checks++;
            assert (q3.size() > 0) else begin
               errors++;
               $error("FAIL sb3_unexpected_exec observed=exec expected=no_exec");
            end
            if (q3.size() > 0) begin
               cur3 = q3.pop_front();
               chk("sb3_operands", 40'({instr3, d0_3, d1_3}), 40'({cur3.instr, cur3.a, cur3.b}));
               pend3 = 1'b1;
            end
         end
      end
   end

   // Strobe one byte: strobe high 4 cycles, data held 8 cycles.
   task automatic strobe_byte(input logic [7:0] b);
      i_data   = b;
      i_strobe = 1'b1;
      repeat (4) @(negedge clk);
      i_strobe = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Strobe operand B and check the exact EXEC/DONE timing of both instances.
   task automatic exec_byte(input logic [7:0] b, input logic [7:0] exp_res);
      i_data   = b;
      i_strobe = 1'b1;
      repeat (3) @(negedge clk);
      chk("exec2_flags", 40'({av2, rv2, busy2}), 40'(3'b101));
      chk("exec2_opb", 40'(d1_2), 40'(b));
      chk("exec3_pre", 40'({av3, busy3}), 40'(2'b01));
      @(negedge clk);
      i_strobe = 1'b0;
      chk("done2_flags", 40'({av2, rv2, busy2, err2}), 40'(4'b0100));
      chk("done2_result", 40'(res2), 40'(exp_res));
      chk("exec3_flags", 40'({av3, rv3, busy3}), 40'(3'b101));
      @(negedge clk);
      chk("done3_flags", 40'({av3, rv3, busy3, err3}), 40'(4'b0100));
      chk("done3_result", 40'(res3), 40'(exp_res));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      i_data   = 8'h00;
      i_strobe = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset2", 40'({instr2, d0_2, d1_2, res2, av2, rv2, err2, busy2}), 40'(0));
      chk("reset3", 40'({instr3, d0_3, d1_3, res3, av3, rv3, err3, busy3}), 40'(0));

      // Plain ADD: 0x04, A=0x05, B=0x03
      strobe_byte(8'h04);
      chk("instr_busy2", 40'({instr2, busy2}), 40'({8'h04, 1'b1}));
      chk("instr_busy3", 40'({instr3, busy3}), 40'({8'h04, 1'b1}));
      strobe_byte(8'h05);
      chk("opa2", 40'({d0_2, busy2, av2}), 40'({8'h05, 1'b1, 1'b0}));
      chk("opa3", 40'({d0_3, busy3, av3}), 40'({8'h05, 1'b1, 1'b0}));
      push_txn(8'h04, 8'h05, 8'h03, 8'h08);
      exec_byte(8'h03, 8'h08);
      chk("exec_count_first", 40'({exec2, exec3}), 40'({32'd1, 32'd1}) & 40'hFF_FFFF_FFFF);

      // Chained ADD: A comes from the previous result 0x08
      strobe_byte(8'h0C);
      chk("chain_a2", 40'({d0_2, busy2, rv2}), 40'({8'h08, 1'b1, 1'b0}));
      chk("chain_a3", 40'({d0_3, busy3, rv3}), 40'({8'h08, 1'b1, 1'b0}));
      push_txn(8'h0C, 8'h08, 8'h02, 8'h0A);
      exec_byte(8'h02, 8'h0A);

      // Unsupported opcode: immediate error result, no EXEC
      strobe_byte(8'h06);
      chk("illegal2", 40'({instr2, res2, err2, rv2, busy2}), 40'({8'h06, 8'h00, 3'b110}));
      chk("illegal3", 40'({instr3, res3, err3, rv3, busy3}), 40'({8'h06, 8'h00, 3'b110}));
      chk("illegal_no_exec2", 40'(exec2), 40'(2));
      chk("illegal_no_exec3", 40'(exec3), 40'(2));

      // Chain after error starts from A=0x00
      strobe_byte(8'h0C);
      chk("chain_after_err2", 40'({d0_2, err2, rv2, busy2}), 40'({8'h00, 3'b001}));
      chk("chain_after_err3", 40'({d0_3, err3, rv3, busy3}), 40'({8'h00, 3'b001}));
      push_txn(8'h0C, 8'h00, 8'h33, 8'h33);
      exec_byte(8'h33, 8'h33);

      // Strobe held high for 20 cycles in OPA loads exactly one byte
      strobe_byte(8'h01);
      i_data   = 8'h5A;
      i_strobe = 1'b1;
      repeat (20) @(negedge clk);
      i_strobe = 1'b0;
      repeat (4) @(negedge clk);
      chk("hold2", 40'({d0_2, busy2, av2}), 40'({8'h5A, 1'b1, 1'b0}));
      chk("hold3", 40'({d0_3, busy3, av3}), 40'({8'h5A, 1'b1, 1'b0}));
      chk("hold_no_exec", 40'({exec2[7:0], exec3[7:0]}), 40'({8'd3, 8'd3}));
      push_txn(8'h01, 8'h5A, 8'h0F, 8'h5F);
      exec_byte(8'h0F, 8'h5F);

      // Reset in OPB discards partial bytes and the chain history
      strobe_byte(8'h01);
      strobe_byte(8'hAA);
      chk("pre_reset_busy", 40'({busy2, busy3, d0_2, d0_3}), 40'({2'b11, 8'hAA, 8'hAA}));
      rst = 1'b1;
      @(negedge clk);
      chk("midop_reset2", 40'({instr2, d0_2, d1_2, res2, av2, rv2, err2, busy2}), 40'(0));
      chk("midop_reset3", 40'({instr3, d0_3, d1_3, res3, av3, rv3, err3, busy3}), 40'(0));
      rst = 1'b0;
      @(negedge clk);
      strobe_byte(8'h0D);
      chk("chain_after_rst2", 40'({instr2, d0_2, busy2}), 40'({8'h0D, 8'h00, 1'b1}));
      chk("chain_after_rst3", 40'({instr3, d0_3, busy3}), 40'({8'h0D, 8'h00, 1'b1}));
      push_txn(8'h0D, 8'h00, 8'h11, 8'hFF);
      exec_byte(8'h11, 8'hFF);

      repeat (4) @(negedge clk);
      chk("sb_drained", 40'({q2.size(), q3.size()}), 40'(0));
      chk("exec_total", 40'({exec2[7:0], exec3[7:0]}), 40'({8'd5, 8'd5}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lingret_alu_loader.md
Name: lingret_alu_loader

Overview:
- Byte-serial front end for the Lingret ALU datapath; sits directly upstream of the combinational ALU.
- Collects an instruction byte, then operand A, then operand B, from one shared 8-bit input bus qualified by a strobe.
- Drives the ALU's instruction and data inputs, captures the ALU result into a register, and holds it on the output pins.
- Supports chaining, where the previous result is reused as operand A, and rejects unsupported opcodes.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the strobe synchronizer (legal range 2..3).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
i_data  input  8  shared byte bus (instruction / operand A / operand B)
i_strobe  input  1  asynchronous load strobe from pin; one byte accepted per rising edge
o_instruction  output  8  instruction byte presented to the ALU
o_data_0  output  8  operand A presented to the ALU
o_data_1  output  8  operand B presented to the ALU
o_alu_valid  output  1  high during the single EXEC cycle when the ALU inputs are final
i_alu_result  input  8  combinational ALU result
o_result  output  8  registered result
o_result_valid  output  1  o_result holds the result of the most recent instruction
o_error  output  1  most recent instruction had an unsupported opcode
o_busy  output  1  an instruction is in progress (in OPA, OPB or EXEC)

Behaviour:
- Reset (rst=1 at a clk edge): state=S_INSTR. All outputs 0. has_prev=0. Synchronizer and edge-detect flops cleared. Reset mid-operation aborts the operation and discards any partial bytes.
- i_strobe passes through SYNC_STAGES flops, then a rising-edge detector.
  - An "accept" is the single cycle in which the synchronized strobe is 1 and its previous value was 0.
  - A strobe held high for N cycles yields exactly one accept.
  - i_data is sampled in the accept cycle. The source holds i_data stable from the strobe rise until SYNC_STAGES+2 cycles after it.
- Opcode is instr[2:0]. Legal opcodes are 000 through 101; 110 and 111 are unsupported. instr[3]=1 selects chain mode. instr[7:4] are passed through unchanged.
- State transitions and actions (each entry: state and condition, then action and next state):
  - S_INSTR or S_DONE, accept, unsupported opcode: latch instr; o_result=0x00; o_error=1; o_result_valid=1; has_prev=0; next S_DONE. No operand bytes are consumed.
  - S_INSTR or S_DONE, accept, legal opcode, chain=0: latch instr; clear o_result_valid and o_error; next S_OPA.
  - S_INSTR or S_DONE, accept, legal opcode, chain=1: latch instr; A = has_prev ? o_result : 0x00; clear o_result_valid and o_error; next S_OPB.
  - S_OPA, accept: A=i_data; next S_OPB.
  - S_OPB, accept: B=i_data; next S_EXEC.
  - S_EXEC, one cycle: o_alu_valid=1; o_result<=i_alu_result at the end of the cycle; o_result_valid=1; has_prev=1; next S_DONE.
  - S_DONE, no accept: hold o_result, o_result_valid and o_error.
- o_instruction, o_data_0 and o_data_1 are registered and update only when their byte is latched. They stay stable through EXEC and DONE.
- o_busy=1 exactly in S_OPA, S_OPB and S_EXEC.
- Latency: o_result_valid rises 2 cycles after the accept that latches operand B (accept cycle, then EXEC, then DONE).
- No accumulator arithmetic is performed in this block. Width handling, including carry drop, is the ALU's responsibility; the 8-bit result is captured verbatim.

Test Plan:
- Reset, then strobe bytes 0x04, 0x05, 0x03 with an ALU model returning 0x08 -> o_data_0=0x05, o_data_1=0x03; o_alu_valid high for exactly 1 cycle; o_result=0x08 and o_result_valid=1 2 cycles after the third accept; o_busy high only between the first accept and DONE.
- Directly after that, strobe 0x0C then 0x02 (chain ADD) -> o_data_0=0x08 with no A byte consumed; o_data_1=0x02; the result from the ALU model (0x0A) appears on o_result.
- Strobe 0x06 -> o_error=1, o_result=0x00, o_result_valid=1, no EXEC cycle. The next byte 0x0C is treated as an instruction and chains with A=0x00.
- Hold i_strobe high for 20 cycles during S_OPA -> exactly one byte is accepted; the FSM is in S_OPB, not S_EXEC.
- Assert rst in S_OPB after 0x01, 0xAA -> all outputs 0 and state S_INSTR on the next edge. Then 0x0D, 0x11 -> A=0x00, because has_prev was cleared by reset.
- Rerun the first scenario with SYNC_STAGES=3 -> identical results, with every accept delayed by 1 extra cycle.
